// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, lane widths
// and the access legality check used at request acceptance.
package lsu_pkg;

    localparam int BYTE_W     = 8;
    localparam int HALF_W     = 16;
    localparam int LANE_SEL_W = 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    // Illegal codes and misaligned halfword/word accesses both report as errors.
    function automatic logic access_err(input logic                  we,
                                        input logic [2:0]            funct3,
                                        input logic [LANE_SEL_W-1:0] addr_lo);
        logic illegal;
        logic misal;
        illegal = 1'b0;
        misal   = 1'b0;
        case (funct3)
            F3_B:  ;
            F3_H:  misal = addr_lo[0];
            F3_W:  misal = |addr_lo;
            F3_BU: illegal = we;
            F3_HU: begin
                illegal = we;
                misal   = addr_lo[0];
            end
            default: illegal = 1'b1;
        endcase
        return illegal | misal;
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core-side request/response handshake plus data RAM port of the load/store unit.
interface lsu_rmw_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // A request transfers on a rising edge where req_valid and req_ready are both high;
    // req_ready is high only in IDLE, resp_valid is a single-cycle pulse with no back-pressure.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               MemRead, MemWrite, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               MemRead, MemWrite, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/halfword extract with sign/zero extension,
// and byte/halfword merge of store data into a previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]            funct3_i,
    input  logic [LANE_SEL_W-1:0] lane_i,
    input  logic [31:0]           load_word_i,
    input  logic [31:0]           merge_word_i,
    input  logic [31:0]           store_data_i,
    output logic [31:0]           load_data_o,
    output logic [31:0]           merged_word_o
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    always_comb begin
        byte_sel = load_word_i[lane_i*BYTE_W +: BYTE_W];
        half_sel = load_word_i[lane_i[1]*HALF_W +: HALF_W];

        case (funct3_i)
            F3_B:    load_data_o = {{(32-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
            F3_H:    load_data_o = {{(32-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            F3_BU:   load_data_o = {{(32-BYTE_W){1'b0}}, byte_sel};
            F3_HU:   load_data_o = {{(32-HALF_W){1'b0}}, half_sel};
            default: load_data_o = load_word_i;
        endcase

        // Untouched lanes keep the value read during RMW_RD.
        merged_word_o = merge_word_i;
        case (funct3_i)
            F3_B:    merged_word_o[lane_i*BYTE_W +: BYTE_W]    = store_data_i[BYTE_W-1:0];
            F3_H:    merged_word_o[lane_i[1]*HALF_W +: HALF_W] = store_data_i[HALF_W-1:0];
            default: merged_word_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit with read-modify-write for sub-word stores against a word-wide RAM.
// Requests are registered at acceptance; every RAM output comes from state and registers.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_rmw_if.slave   bus,
    output lsu_state_e state_o
);

    lsu_state_e         state_q, state_d;
    logic               we_q;
    logic [2:0]         funct3_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        merge_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic               accept;
    logic               req_err;
    logic [31:0]        load_data;
    logic [31:0]        merged_word;

    assign accept  = bus.req_valid && (state_q == ST_IDLE);
    assign req_err = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign state_o = state_q;

    lsu_align u_align (
        .funct3_i      (funct3_q),
        .lane_i        (addr_q[1:0]),
        .load_word_i   (bus.mem_rdata),
        .merge_word_i  (merge_q),
        .store_data_i  (wdata_q),
        .load_data_o   (load_data),
        .merged_word_o (merged_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                       state_d = ST_RESP;
                    else if (!bus.req_we)              state_d = ST_LOAD;
                    else if (bus.req_funct3 == F3_W)   state_d = ST_WRITE;
                    else                               state_d = ST_RMW_RD;
                end
            end
            ST_LOAD:   state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_WRITE;
            ST_WRITE:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr[ADDR_W+1:0];
                wdata_q  <= bus.req_wdata;
                err_q    <= req_err;
                rdata_q  <= '0;
            end
            if (state_q == ST_LOAD) begin
                rdata_q <= load_data;
            end
            if (state_q == ST_RMW_RD) begin
                merge_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.mem_wdata  = '0;
        bus.mem_addr   = 32'(addr_q[ADDR_W+1:2]);
        case (state_q)
            ST_IDLE:            bus.req_ready = 1'b1;
            ST_LOAD, ST_RMW_RD: bus.MemRead   = 1'b1;
            ST_WRITE: begin
                bus.MemWrite  = we_q;
                bus.mem_wdata = merged_word;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed and randomized checks of lsu_rmw against a byte-addressed memory model.
module tb_lsu_rmw;
    import lsu_pkg::*;

    localparam int RAM_WORDS = 1 << 14;

    logic       clk;
    logic       rst_n;
    lsu_state_e state_o;
    lsu_rmw_if  bus ();

    int vectors;
    int miscompares;

    logic [31:0] ram [0:RAM_WORDS-1];
    logic [7:0]  ref_mem [0:1023];

    lsu_rmw #(.ADDR_W(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = ram[bus.mem_addr[13:0]];

    always @(negedge clk) begin
        if (bus.MemWrite) ram[bus.mem_addr[13:0]] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = acc_size(f3);
        if (sz == 0) return 1'b1;
        if (we && f3[2]) return 1'b1;
        return (int'(addr) % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        logic [31:0] v;
        sz = acc_size(f3);
        v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        int sz;
        sz = acc_size(f3);
        for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = 8'(data >> (8 * i));
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int a;
        a = int'(addr) & ~3;
        return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag, output logic [31:0] rdata);
        bit          exp_err, exp_rd, exp_wr;
        bit          any_rd, any_wr, both;
        int          exp_lat, lat;
        logic [31:0] exp_rdata, wr_addr;
        logic        err_obs;
        exp_err   = model_err(we, f3, addr);
        exp_lat   = exp_err ? 1 : ((we && acc_size(f3) < 4) ? 3 : 2);
        exp_rdata = (exp_err || we) ? 32'h0 : model_load(f3, addr);
        exp_wr    = !exp_err && we;
        exp_rd    = !exp_err && !(we && f3 == 3'd2);
        any_rd = 0; any_wr = 0; both = 0; lat = 0;
        wr_addr = '0; rdata = '0; err_obs = 1'b0;

        @(negedge clk);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.MemRead && bus.MemWrite) both = 1;
            if (bus.MemRead) any_rd = 1;
            if (bus.MemWrite) begin
                any_wr  = 1;
                wr_addr = bus.mem_addr;
            end
            if (bus.resp_valid) begin
                lat     = c;
                rdata   = bus.resp_rdata;
                err_obs = bus.resp_err;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(err_obs), 32'(exp_err));
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_memread"}, 32'(any_rd), 32'(exp_rd));
        check({tag, "_memwrite"}, 32'(any_wr), 32'(exp_wr));
        check({tag, "_strobe_overlap"}, 32'(both), 32'd0);
        if (exp_wr) begin
            check({tag, "_mem_addr"}, wr_addr, addr >> 2);
            model_store(f3, addr, wdata);
        end
        @(negedge clk);
        check({tag, "_resp_pulse"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_ram_word"}, ram[addr[15:2]], model_word(addr));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] word_before;
        logic [2:0]  f3;
        logic        we;
        int          resp_n, resp1_c, resp2_c, wr_c, rd_c, ready_c;
        bit          lw_pending, overlap, wr_seen;
        logic [31:0] resp2_data;

        vectors     = 0;
        miscompares = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < RAM_WORDS; i++) ram[i] = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = 8'(ram[i] >> (8 * b));
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_strobes", 32'({bus.MemRead, bus.MemWrite}), 32'd0);
        check("rst_state", 32'(state_o), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_rdata", bus.resp_rdata, 32'd0);

        // Word store then load.
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw10", rd);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw10", rd);
        check("lw10_const", rd, 32'hDEAD_BEEF);

        // Sub-word loads with sign and zero extension.
        do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, "sw20a", rd);
        do_req(1'b0, 3'b000, 32'h23, 32'h0, "lb23", rd);
        check("lb23_const", rd, 32'h0000_0011);
        do_req(1'b0, 3'b100, 32'h21, 32'h0, "lbu21", rd);
        check("lbu21_const", rd, 32'h0000_0033);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, "lh22", rd);
        check("lh22_const", rd, 32'h0000_1122);
        do_req(1'b1, 3'b010, 32'h20, 32'h80FF_0000, "sw20b", rd);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, "lh22neg", rd);
        check("lh22neg_const", rd, 32'hFFFF_80FF);

        // Read-modify-write stores.
        do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, "sw20c", rd);
        do_req(1'b1, 3'b000, 32'h21, 32'h0000_00AA, "sb21", rd);
        check("sb21_word", ram[8], 32'h1122_AA44);
        do_req(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, "sh22", rd);
        check("sh22_word", ram[8], 32'hBEEF_AA44);

        // Errors.
        do_req(1'b0, 3'b010, 32'h22, 32'h0, "lw22_mis", rd);
        do_req(1'b1, 3'b001, 32'h21, 32'h1234, "sh21_mis", rd);
        do_req(1'b0, 3'b011, 32'h20, 32'h0, "f3_011", rd);
        do_req(1'b1, 3'b100, 32'h20, 32'h55, "sbu_illegal", rd);

        // Reset while an SB sits in RMW_RD: no write, no response.
        word_before = ram[12];
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h31;
        bus.req_wdata = 32'h55; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstrmw_state", 32'(state_o), 32'(ST_RMW_RD));
        rst_n = 1'b0;
        wr_seen = 0; resp_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        if (bus.resp_valid) resp_n++;
        if (bus.MemWrite) wr_seen = 1;
        @(negedge clk);
        check("rstrmw_ready", 32'(bus.req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (bus.resp_valid) resp_n++;
            if (bus.MemWrite) wr_seen = 1;
            @(negedge clk);
        end
        check("rstrmw_no_resp", 32'(resp_n), 32'd0);
        check("rstrmw_no_write", 32'(wr_seen), 32'd0);
        check("rstrmw_word", ram[12], word_before);
        check("rstrmw_word_model", ram[12], model_word(32'h30));

        // Reset during WRITE: the write lands, no response follows.
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h35;
        bus.req_wdata = 32'h77; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rstwr_memwrite", 32'(bus.MemWrite), 32'd1);
        rst_n = 1'b0;
        model_store(3'b000, 32'h35, 32'h77);
        resp_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        if (bus.resp_valid) resp_n++;
        @(negedge clk);
        if (bus.resp_valid) resp_n++;
        check("rstwr_no_resp", 32'(resp_n), 32'd0);
        check("rstwr_ready", 32'(bus.req_ready), 32'd1);
        check("rstwr_word", ram[13], model_word(32'h34));

        // Back-to-back SW then LW with req_valid held high.
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h40;
        bus.req_wdata = 32'hCAFE_F00D; bus.req_valid = 1'b1;
        check("b2b_ready0", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        resp_n = 0; resp1_c = 0; resp2_c = 0; wr_c = 0; rd_c = 0; ready_c = 0;
        lw_pending = 0; overlap = 0; resp2_data = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.MemRead && bus.MemWrite) overlap = 1;
            if (bus.MemWrite && wr_c == 0) wr_c = c;
            if (bus.MemRead && rd_c == 0) rd_c = c;
            if (lw_pending) begin
                bus.req_valid = 1'b0;
                lw_pending = 0;
            end
            if (c == 1) begin
                bus.req_we = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = '0;
            end else if (bus.req_valid && bus.req_ready) begin
                lw_pending = 1;
                if (ready_c == 0) ready_c = c;
            end
            if (bus.resp_valid) begin
                resp_n++;
                if (resp_n == 1) resp1_c = c;
                else begin
                    resp2_c = c;
                    resp2_data = bus.resp_rdata;
                end
            end
            if (resp_n == 2) break;
        end
        model_store(3'b010, 32'h40, 32'hCAFE_F00D);
        check("b2b_resp_count", 32'(resp_n), 32'd2);
        check("b2b_sw_write_cycle", 32'(wr_c), 32'd1);
        check("b2b_sw_resp_cycle", 32'(resp1_c), 32'd2);
        check("b2b_ready_again", 32'(ready_c), 32'd3);
        check("b2b_lw_read_cycle", 32'(rd_c), 32'd4);
        check("b2b_lw_resp_cycle", 32'(resp2_c), 32'd5);
        check("b2b_lw_data", resp2_data, 32'hCAFE_F00D);
        check("b2b_overlap", 32'(overlap), 32'd0);

        // Randomized traffic, mostly legal codes.
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = we ? 3'b000 : 3'b100;
                    default: f3 = we ? 3'b001 : 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            do_req(we, f3, 32'($urandom_range(0, 255)), $urandom, "rand", rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
